// File: rtl/key_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : key_debounce
// Description: Per-key 2-flop synchroniser and bounce filter with press and
//              release strobes aligned to the debounced level.
// Revision   : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int   KEY_NUM = 4,
    parameter int   CNT_MAX = 1_000_000,
    parameter logic RST_LVL = 1'b1
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_out,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release
);

    localparam int               C_CNT_W    = $clog2(CNT_MAX);
    localparam logic [C_CNT_W-1:0] C_CNT_TERM = C_CNT_W'(CNT_MAX - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [KEY_NUM-1:0] C_IDLE     = {KEY_NUM{RST_LVL}};

    logic [KEY_NUM-1:0] sync1_q, sync1_d;
    logic [KEY_NUM-1:0] sync2_q, sync2_d;
    logic [KEY_NUM-1:0] key_out_q, key_out_d;
    logic [KEY_NUM-1:0] key_press_q, key_press_d;
    logic [KEY_NUM-1:0] key_release_q, key_release_d;
    logic [C_CNT_W-1:0] cnt_q [KEY_NUM];
    logic [C_CNT_W-1:0] cnt_d [KEY_NUM];

    always_comb begin
        sync1_d       = key_in;
        sync2_d       = sync1_q;
        key_out_d     = key_out_q;
        key_press_d   = '0;
        key_release_d = '0;
        cnt_d         = '{default: '0};
        // A channel counts only while its synchronised level disagrees with
        // the debounced level; any agreement drops the count back to zero.
        for (int i = 0; i < KEY_NUM; i++) begin
            if (sync2_q[i] != key_out_q[i]) begin
                if (cnt_q[i] == C_CNT_TERM) begin
                    key_out_d[i]     = sync2_q[i];
                    key_press_d[i]   = (sync2_q[i] != RST_LVL);
                    key_release_d[i] = (sync2_q[i] == RST_LVL);
                end else begin
                    cnt_d[i] = cnt_q[i] + C_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q       <= C_IDLE;
            sync2_q       <= C_IDLE;
            key_out_q     <= C_IDLE;
            key_press_q   <= '0;
            key_release_q <= '0;
            cnt_q         <= '{default: '0};
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            key_out_q     <= key_out_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            cnt_q         <= cnt_d;
        end
    end

    assign key_out     = key_out_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_key_debounce
// Description: Directed stimulus with a strobe scoreboard for key_debounce.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int C_KEYS = 4;
    localparam int C_CNT  = 8;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lvl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in = 4'hF;
    logic [3:0] key_out;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    key_debounce #(
        .KEY_NUM (C_KEYS),
        .CNT_MAX (C_CNT),
        .RST_LVL (1'b1)
    ) dut (
        .sys_clk     (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected strobe lands CNT+2 edges after the negedge that changed key_in.
    task automatic expect_strobe(input logic [3:0] press, input logic [3:0] rel,
                                 input logic [3:0] lvl);
        exp_t e;
        e.cyc = cyc + C_CNT + 2;
        e.press = press;
        e.rel = rel;
        e.lvl = lvl;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if ((key_press | key_release) != 4'h0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got press=%h release=%h out=%h expected none (cycle %0d)",
                         key_press, key_release, key_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release
                    || e.lvl !== key_out) begin
                    failures++;
                    $display("FAIL strobe: got cyc=%0d press=%h release=%h out=%h expected cyc=%0d press=%h release=%h out=%h",
                             cyc, key_press, key_release, key_out, e.cyc, e.press, e.rel, e.lvl);
                end
            end
        end
    end

    initial begin
        // Reset held, then idle with keys released.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("reset_key_out", key_out, 4'hF);
            chk("reset_strobes", key_press | key_release, 4'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_key_out", key_out, 4'hF);
        end

        // Single key press and release.
        key_in = 4'hE;
        expect_strobe(4'h1, 4'h0, 4'hE);
        tick(9);
        chk("press0_before_edge10", key_out, 4'hF);
        tick(1);
        chk("press0_edge10", key_out, 4'hE);
        tick(5);
        key_in = 4'hF;
        expect_strobe(4'h0, 4'h1, 4'hF);
        tick(12);
        chk("release0_level", key_out, 4'hF);

        // Bouncing key 1, finally settling low.
        for (int i = 0; i < 13; i++) begin
            key_in[1] = ~key_in[1];
            if (i < 12) tick(3);
        end
        chk("bounce1_no_change", key_out, 4'hF);
        expect_strobe(4'h2, 4'h0, 4'hD);
        tick(12);
        chk("bounce1_settled", key_out, 4'hD);
        key_in = 4'hF;
        expect_strobe(4'h0, 4'h2, 4'hF);
        tick(12);

        // Short glitch rejected, long pulse accepted.
        key_in[2] = 1'b0;
        tick(7);
        key_in[2] = 1'b1;
        tick(15);
        chk("glitch2_rejected", key_out, 4'hF);
        key_in[2] = 1'b0;
        expect_strobe(4'h4, 4'h0, 4'hB);
        tick(12);
        key_in[2] = 1'b1;
        expect_strobe(4'h0, 4'h4, 4'hF);
        tick(12);
        chk("pulse2_done", key_out, 4'hF);

        // All keys together.
        key_in = 4'h0;
        expect_strobe(4'hF, 4'h0, 4'h0);
        tick(12);
        chk("all_pressed", key_out, 4'h0);
        key_in = 4'hF;
        expect_strobe(4'h0, 4'hF, 4'hF);
        tick(12);

        // Reset in mid-count re-qualifies the held key from zero.
        key_in = 4'h7;
        tick(7);
        rst = 1'b1;
        tick(1);
        chk("midcount_reset_out", key_out, 4'hF);
        rst = 1'b0;
        expect_strobe(4'h8, 4'h0, 4'h7);
        tick(9);
        chk("requal3_before", key_out, 4'hF);
        tick(1);
        chk("requal3_edge10", key_out, 4'h7);
        tick(3);
        key_in = 4'hF;
        expect_strobe(4'h0, 4'h8, 4'hF);
        tick(14);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
